// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM encoding,
// register offsets, CTRL bit positions and the byte-lane merge helper.
package timer_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/timer_device.sv
// Countdown timer on the CPU data-memory port: CTRL/PRESET/COUNT registers,
// a four-state load/count FSM and a maskable interrupt (one-shot or auto-reload).
module timer_device
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic [3:0]  byteEn,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [3:0]       ctrl;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic [1:0]       state;
    logic             pending;

    logic [31:0] cur_reg;
    logic [31:0] wr_merged;
    logic        wr_en, ctrl_wr, preset_wr;
    logic        en, reload, hit_zero;

    assign en        = ctrl[CTRL_EN];
    assign reload    = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
    assign wr_en     = sel & (|byteEn);
    assign ctrl_wr   = wr_en & (addr == ADDR_CTRL);
    assign preset_wr = wr_en & (addr == ADDR_PRESET);
    assign hit_zero  = (state == S_CNT) & en & (count == '0);

    always_comb begin
        cur_reg = '0;
        case (addr)
            ADDR_CTRL:   cur_reg = {28'd0, ctrl};
            ADDR_PRESET: cur_reg = 32'(preset);
            ADDR_COUNT:  cur_reg = 32'(count);
            default:     cur_reg = '0;
        endcase
    end

    assign wr_merged = merge_be(cur_reg, wdata, byteEn);
    assign rdata     = sel ? cur_reg : 32'd0;
    assign irq       = pending & ctrl[CTRL_IM];

    // A CPU write to CTRL in the INT cycle takes precedence over the one-shot EN clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl    <= '0;
            preset  <= '0;
            pending <= 1'b0;
        end else begin
            if (ctrl_wr)
                ctrl <= wr_merged[3:0];
            else if (state == S_INT && !reload)
                ctrl[CTRL_EN] <= 1'b0;

            if (preset_wr)
                preset <= CNT_W'(wr_merged);

            if (hit_zero)
                pending <= 1'b1;
            else if (ctrl_wr)
                pending <= 1'b0;
            else if (state == S_INT && reload)
                pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            case (state)
                S_IDLE: if (en) state <= S_LOAD;
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!en)
                        state <= S_IDLE;
                    else if (count == '0)
                        state <= S_INT;
                    else
                        count <= count - CNT_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
